// File: rtl/pc_redirect_control_pkg.sv
// pc_redirect_control_pkg: shared widths, reset PC, FSM states and alignment helper
package pc_redirect_control_pkg;
    localparam int XLEN = 32;
    localparam int IALIGN = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN = 2'd1,
        SHADOW = 2'd2,
        TRAP = 2'd3
    } pcState_t;
    function automatic logic isAligned(input logic [XLEN-1:0] addr);
        return addr[$clog2(IALIGN)-1:0] == '0;
    endfunction
endpackage

// File: rtl/pc_redirect_control_if.sv
// pc_redirect_control_if: EX jump decision in, fetch request and trap status out
interface pc_redirect_control_if;
    import pc_redirect_control_pkg::*;
    logic jump;
    logic jumpValid;
    logic [XLEN-1:0] jumpTarget;
    logic stall;
    logic fetchReady;
    logic [XLEN-1:0] pc;
    logic fetchValid;
    logic flush;
    logic redirect;
    logic misalignTrap;
    logic [XLEN-1:0] badTarget;
    modport master (
        output jump, jumpValid, jumpTarget, stall, fetchReady,
        input pc, fetchValid, flush, redirect, misalignTrap, badTarget
    );
    modport slave (
        input jump, jumpValid, jumpTarget, stall, fetchReady,
        output pc, fetchValid, flush, redirect, misalignTrap, badTarget
    );
endinterface

// File: rtl/pc_redirect_control_flush_counter.sv
// pc_redirect_control_flush_counter: loadable down-counter timing the post-redirect shadow
module pc_redirect_control_flush_counter #(
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    input logic load,
    output logic done
);
    localparam int W = $clog2(FLUSH_CYCLES + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= W'(FLUSH_CYCLES);
        else if (count != '0) count <= count - W'(1);
    end
    // Last shadow cycle is the one where the count reads 1.
    assign done = count == W'(1);
endmodule

// File: rtl/pc_redirect_control.sv
// pc_redirect_control: owns the fetch PC, applies EX redirects with a flush shadow,
// and traps stickily on misaligned targets.
module pc_redirect_control
    import pc_redirect_control_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    pc_redirect_control_if.slave bus
);
    pcState_t state, nextState;
    logic accept, aligned, shadowDone, take;
    assign accept = state == RUN && bus.jump && bus.jumpValid;
    assign aligned = isAligned(bus.jumpTarget);
    assign take = accept && aligned;
    pc_redirect_control_flush_counter #(.FLUSH_CYCLES(FLUSH_CYCLES)) flushCounter (
        .clk(clk),
        .rst(rst),
        .load(take),
        .done(shadowDone)
    );
    always_comb begin
        nextState = state;
        nextState = state == BOOT ? RUN :
                    accept ? (aligned ? SHADOW : TRAP) :
                    (state == SHADOW && shadowDone) ? RUN : state;
    end
    assign bus.fetchValid = state == RUN || state == SHADOW;
    assign bus.flush = accept || state == TRAP;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            bus.pc <= RESET_PC;
            bus.redirect <= 1'b0;
            bus.misalignTrap <= 1'b0;
            bus.badTarget <= '0;
        end else begin
            state <= nextState;
            bus.redirect <= take;
            // A taken jump abandons any pending fetch, stalled or not.
            if (take) bus.pc <= bus.jumpTarget;
            else if (!accept && bus.fetchValid && bus.fetchReady && !bus.stall)
                bus.pc <= bus.pc + XLEN'(IALIGN);
            if (accept && !aligned) begin
                bus.misalignTrap <= 1'b1;
                bus.badTarget <= bus.jumpTarget;
            end
        end
    end
endmodule

// File: tb/tb_pc_redirect_control.sv
// tb_pc_redirect_control: directed scenarios plus random traffic against a
// behavioural model of fetch PC, shadow window and trap.
module tb_pc_redirect_control;
    import pc_redirect_control_pkg::*;
    localparam int FLUSH = 2;
    localparam logic [31:0] RPC = 32'h0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pc_redirect_control_if bus();
    pc_redirect_control #(.RESET_PC(RPC), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] mPc, mBad;
    bit mBooting, mTrapped, mRedirect;
    int mShadow;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = RPC;
        mBad = '0;
        mBooting = 1;
        mTrapped = 0;
        mRedirect = 0;
        mShadow = 0;
    endtask

    task automatic drive(input logic j, input logic jv, input logic [31:0] t, input logic s, input logic r);
        bus.jump = j;
        bus.jumpValid = jv;
        bus.jumpTarget = t;
        bus.stall = s;
        bus.fetchReady = r;
    endtask

    // Called at a negedge with reset released; returns at the following negedge.
    task automatic cycle(input logic j, input logic jv, input logic [31:0] t, input logic s, input logic r);
        bit live, acc;
        drive(j, jv, t, s, r);
        #1;
        live = !mBooting && !mTrapped;
        acc = live && mShadow == 0 && j && jv;
        checkEq("pc", bus.pc, mPc);
        checkEq("fetchValid", bus.fetchValid, live);
        checkEq("flush", bus.flush, acc || mTrapped);
        checkEq("redirect", bus.redirect, mRedirect);
        checkEq("misalignTrap", bus.misalignTrap, mTrapped);
        checkEq("badTarget", bus.badTarget, mBad);
        @(posedge clk);
        mRedirect = acc && (t % 4 == 0);
        if (mBooting) mBooting = 0;
        else if (acc && t % 4 == 0) begin
            mPc = t;
            mShadow = FLUSH;
        end else if (acc) begin
            mTrapped = 1;
            mBad = t;
        end else if (live) begin
            if (r && !s) mPc = mPc + 32'd4;
            if (mShadow > 0) mShadow--;
        end
        @(negedge clk);
    endtask

    // Asynchronous assertion mid-cycle; outputs must drop before any edge.
    task automatic applyReset();
        drive(0, 0, '0, 0, 0);
        rst = 1'b1;
        #1;
        checkEq("rst pc", bus.pc, RPC);
        checkEq("rst fetchValid", bus.fetchValid, 0);
        checkEq("rst flush", bus.flush, 0);
        checkEq("rst redirect", bus.redirect, 0);
        checkEq("rst trap", bus.misalignTrap, 0);
        checkEq("rst badTarget", bus.badTarget, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, '0, 0, 0);
        modelReset();
        @(negedge clk);
        applyReset();
        repeat (5) cycle(0, 0, '0, 0, 1);
        cycle(1, 1, 32'h80, 0, 1);
        repeat (2) cycle(1, 1, 32'h200, 0, 1);
        repeat (2) cycle(0, 0, '0, 0, 1);
        cycle(1, 1, 32'h40, 1, 0);
        repeat (2) cycle(0, 0, '0, 0, 1);
        repeat (3) cycle(0, 0, '0, 1, 1);
        repeat (2) cycle(0, 0, '0, 1, 0);
        cycle(1, 1, mPc, 0, 1);
        repeat (3) cycle(0, 0, '0, 0, 1);
        cycle(1, 0, 32'h300, 0, 1);
        cycle(1, 1, 32'hFFFF_FFF8, 0, 1);
        repeat (4) cycle(0, 0, '0, 0, 1);
        cycle(1, 1, 32'h102, 0, 1);
        repeat (3) cycle(1, 1, 32'h300, 0, 1);
        applyReset();
        repeat (2) cycle(0, 0, '0, 0, 1);
        cycle(1, 1, 32'h500, 0, 1);
        applyReset();
        repeat (3) cycle(0, 0, '0, 0, 1);
        repeat (800) begin
            if ((mTrapped && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                applyReset();
            else
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                      $urandom_range(0, 15) == 0 ? 32'($urandom) : (32'($urandom) & ~32'h3),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
